// File: rtl/rx_bit_timer_if.sv
// rx_bit_timer_if
// Groups the receive-path signals around the bit timer. The master side is
// whatever feeds the bit timer and consumes its strobes (edge detector plus
// shift register, or a testbench). The slave side is the bit timer itself.
//
// Signals:
//   enable         master -> slave  receiver active; low forces the timer idle
//   edge_detected  master -> slave  one-cycle pulse per line transition
//   d_sync         master -> slave  synchronized line level, aligned with edge_detected
//   shift_enable   slave -> master  one-cycle strobe: d_bit valid, shift it in
//   d_bit          slave -> master  NRZI-decoded data bit
//   byte_received  slave -> master  one-cycle pulse with the last shift of a byte
//   stuff_err      slave -> master  one-cycle pulse on a bit-stuff violation
interface rx_bit_timer_if;
   logic enable;
   logic edge_detected;
   logic d_sync;
   logic shift_enable;
   logic d_bit;
   logic byte_received;
   logic stuff_err;

   modport master (
      output enable,
      output edge_detected,
      output d_sync,
      input  shift_enable,
      input  d_bit,
      input  byte_received,
      input  stuff_err
   );

   modport slave (
      input  enable,
      input  edge_detected,
      input  d_sync,
      output shift_enable,
      output d_bit,
      output byte_received,
      output stuff_err
   );
endinterface

// File: rtl/rx_bit_timer.sv
// rx_bit_timer
// Bit-timing and decode controller for the serial receive path. A phase
// counter is resynchronised on every line transition, the line is sampled
// mid-bit, NRZI-decoded (no transition = 1), stuffed zeros are dropped and
// the downstream shift register is driven with per-bit and per-byte strobes.
//
// Ports:
//   clk   system clock, all logic on the rising edge
//   rst   synchronous active-high reset
//   bus   rx_bit_timer_if slave modport (enable, edge_detected, d_sync in;
//         shift_enable, d_bit, byte_received, stuff_err out)
module rx_bit_timer #(
   parameter int CLKS_PER_BIT  = 8,
   parameter int SAMPLE_PT     = CLKS_PER_BIT / 2,
   parameter int BITS_PER_BYTE = 8,
   parameter int STUFF_LEN     = 6
) (
   input  logic           clk,
   input  logic           rst,
   rx_bit_timer_if.slave  bus
);

   localparam int PW = $clog2(CLKS_PER_BIT);
   localparam int BW = (BITS_PER_BYTE > 1) ? $clog2(BITS_PER_BYTE) : 1;
   localparam int OW = $clog2(STUFF_LEN + 1);

   localparam logic [PW-1:0] PHASE_LAST   = PW'(CLKS_PER_BIT - 1);
   localparam logic [PW-1:0] PHASE_SAMPLE = PW'(SAMPLE_PT);
   localparam logic [PW-1:0] PHASE_RESYNC = PW'(1);
   localparam logic [BW-1:0] BIT_LAST     = BW'(BITS_PER_BYTE - 1);
   localparam logic [OW-1:0] ONES_MAX     = OW'(STUFF_LEN);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t          state;
   logic [PW-1:0]   phase_cnt;
   logic [BW-1:0]   bit_cnt;
   logic [OW-1:0]   ones_cnt;
   logic            prev_level;

   logic            shift_enable_q;
   logic            d_bit_q;
   logic            byte_received_q;
   logic            stuff_err_q;

   logic            sample_now;
   logic            raw_bit;
   logic            emit_bit;
   logic            stuff_violation;

   // Decide what the current cycle does with the line. A sample only happens
   // mid-bit and only when no edge arrives in the same cycle (the edge wins
   // and resyncs instead). Once STUFF_LEN ones have been seen the next sample
   // is never shifted: a zero there is the stuffed bit, a one is a violation.
   always_comb begin
      sample_now      = 1'b0;
      raw_bit         = 1'b0;
      emit_bit        = 1'b0;
      stuff_violation = 1'b0;
      sample_now      = (state == RUN) && (phase_cnt == PHASE_SAMPLE) && !bus.edge_detected;
      raw_bit         = (bus.d_sync == prev_level);
      emit_bit        = sample_now && (ones_cnt != ONES_MAX);
      stuff_violation = sample_now && raw_bit && (ones_cnt == ONES_MAX);
   end

   // Main controller: IDLE waits for the first transition, RUN tracks bit
   // phase and decodes. All strobes are registered, so they appear one cycle
   // after the sample that produced them and default back to zero each cycle.
   // Dropping enable returns everything to the idle-line state, but a strobe
   // registered the cycle before still shows up because it is already in the
   // output flops.
   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         phase_cnt       <= '0;
         bit_cnt         <= '0;
         ones_cnt        <= '0;
         prev_level      <= 1'b1;
         shift_enable_q  <= 1'b0;
         d_bit_q         <= 1'b0;
         byte_received_q <= 1'b0;
         stuff_err_q     <= 1'b0;
      end else begin
         shift_enable_q  <= 1'b0;
         byte_received_q <= 1'b0;
         stuff_err_q     <= 1'b0;

         if (!bus.enable) begin
            state      <= IDLE;
            phase_cnt  <= '0;
            bit_cnt    <= '0;
            ones_cnt   <= '0;
            prev_level <= 1'b1;
         end else begin
            case (state)
               IDLE: begin
                  phase_cnt <= '0;
                  if (bus.edge_detected) begin
                     state     <= RUN;
                     phase_cnt <= PHASE_RESYNC;
                  end
               end

               RUN: begin
                  if (bus.edge_detected) begin
                     phase_cnt <= PHASE_RESYNC;
                  end else if (phase_cnt == PHASE_LAST) begin
                     phase_cnt <= '0;
                  end else begin
                     phase_cnt <= phase_cnt + PW'(1);
                  end

                  if (sample_now) begin
                     prev_level <= bus.d_sync;
                     ones_cnt   <= raw_bit ? ones_cnt + OW'(1) : '0;
                  end

                  if (emit_bit) begin
                     shift_enable_q <= 1'b1;
                     d_bit_q        <= raw_bit;
                     if (bit_cnt == BIT_LAST) begin
                        byte_received_q <= 1'b1;
                        bit_cnt         <= '0;
                     end else begin
                        bit_cnt <= bit_cnt + BW'(1);
                     end
                  end

                  if (stuff_violation) begin
                     stuff_err_q <= 1'b1;
                     state       <= IDLE;
                     phase_cnt   <= '0;
                     bit_cnt     <= '0;
                     ones_cnt    <= '0;
                     prev_level  <= 1'b1;
                  end
               end

               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

   assign bus.shift_enable  = shift_enable_q;
   assign bus.d_bit         = d_bit_q;
   assign bus.byte_received = byte_received_q;
   assign bus.stuff_err     = stuff_err_q;

endmodule

// File: doc/rx_bit_timer.md
Name: rx_bit_timer

Overview:
- Bit-timing and decode controller for the serial receive path.
- Takes the transition pulse from the line edge detector and the synchronized line level, and recovers bit timing by resyncing a phase counter on every edge.
- Samples mid-bit, NRZI-decodes, removes stuffed bits and sequences the downstream shift register with per-bit and per-byte strobes.

Parameters:
- CLKS_PER_BIT, 8: system clocks per serial bit. Must be ≥4.
- SAMPLE_PT, CLKS_PER_BIT/2: phase at which the line is sampled.
- BITS_PER_BYTE, 8: shifts per byte_received pulse.
- STUFF_LEN, 6: consecutive decoded 1s after which a stuffed 0 is required.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- enable  in  1  receiver active; low forces IDLE
- edge_detected  in  1  one-cycle pulse per line transition, from the edge detector
- d_sync  in  1  synchronized line level, aligned with edge_detected
- shift_enable  out  1  one-cycle strobe: d_bit valid, shift it in
- d_bit  out  1  NRZI-decoded data bit; meaningful only with shift_enable
- byte_received  out  1  one-cycle pulse coincident with the BITS_PER_BYTE-th shift_enable
- stuff_err  out  1  one-cycle pulse on a bit-stuff violation

Behaviour:
- Reset (rst=1 at a clock edge), takes effect next cycle:
  - state=IDLE; phase_cnt, ones_cnt, bit_cnt = 0.
  - prev_level=1 (idle line).
  - All outputs 0.
  - rst overrides every other input.
- States: IDLE, RUN.
- IDLE:
  - phase_cnt held 0; no strobes.
  - enable=1 & edge_detected=1 → RUN with phase_cnt=1. The edge cycle counts as phase 0.
- RUN, each cycle:
  - edge_detected=1 → phase_cnt=1 (resync).
  - Otherwise phase_cnt increments, wrapping CLKS_PER_BIT-1 → 0.
- Sample event: in RUN, phase_cnt==SAMPLE_PT and edge_detected=0.
  - Edge coincident with SAMPLE_PT: the edge wins. Resync; no sample that cycle.
- At each sample event:
  - raw = (d_sync == prev_level); prev_level ← d_sync.
  - raw=1 and ones_cnt<STUFF_LEN: ones_cnt++, emit bit 1.
  - raw=1 and ones_cnt==STUFF_LEN: stuff_err pulse next cycle; state → IDLE; all counters cleared; no shift.
  - raw=0 and ones_cnt==STUFF_LEN: stuffed bit. Discard (no shift); ones_cnt=0.
  - raw=0 otherwise: ones_cnt=0, emit bit 0.
- Emitting a bit:
  - shift_enable=1 and d_bit=bit exactly one cycle after the sample cycle (registered).
  - bit_cnt increments on each shift_enable.
- Byte boundary:
  - On the shift_enable where bit_cnt==BITS_PER_BYTE-1, byte_received=1 in the same cycle and bit_cnt wraps to 0.
- Latency:
  - Edge in IDLE at cycle t → first sample at t+SAMPLE_PT → shift_enable at t+SAMPLE_PT+1 (t+5 at defaults).
  - With no further edges, subsequent samples occur every CLKS_PER_BIT cycles.
- d_bit when shift_enable=0: holds last value; no requirement on it.
- enable=0 in any state:
  - Next cycle IDLE; phase_cnt, ones_cnt, bit_cnt = 0; prev_level=1.
  - Any strobe already registered from the previous cycle still appears.
  - Partial byte discarded; no byte_received.
- Re-enable: requires a new edge to enter RUN; bit_cnt starts from 0.
- Widths:
  - phase_cnt: $clog2(CLKS_PER_BIT) bits.
  - bit_cnt: $clog2(BITS_PER_BYTE) bits.
  - ones_cnt: $clog2(STUFF_LEN+1) bits.
  - No counter exceeds its terminal value.

Test Plan (defaults: CLKS_PER_BIT=8, SAMPLE_PT=4, BITS_PER_BYTE=8, STUFF_LEN=6):
- Reset:
  - Stimulus: rst=1 for 2 cycles, then enable=0 with edge_detected pulsing.
  - Required: shift_enable, byte_received, stuff_err all 0 throughout; state stays IDLE.
- Byte 0x80, LSB first:
  - Stimulus: enable=1; NRZI-encode bits 0,0,0,0,0,0,0,1 at 8 clk/bit; first edge at cycle t.
  - Required: 8 shift_enable pulses at t+5, t+13, …, t+61; d_bit = 0000 0001; byte_received only at t+61.
- Bit stuffing:
  - Stimulus: decoded 1×6, stuffed 0, then 1.
  - Required: 6 shifts with d_bit=1; no shift for the stuffed bit; then a shift with d_bit=1; stuff_err stays 0.
- Stuff error:
  - Stimulus: 7 consecutive decoded 1s.
  - Required: stuff_err one pulse one cycle after the 7th sample; no 7th shift; no strobes until a new edge.
- Resync:
  - Stimulus: one bit shortened to 6 clocks.
  - Required: next shift_enable exactly 5 cycles after that edge.
  - Stimulus: edge injected when phase_cnt==4.
  - Required: no sample that cycle; next shift_enable 5 cycles after the edge.
- Enable drop:
  - Stimulus: enable falls after 3 shifts; later re-enable with a full byte.
  - Required: no byte_received for the partial byte; byte_received on the 8th new shift_enable.
